// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the M-extension unit.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface muldiv_unit_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [TAG_WIDTH-1:0] rd_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      result;
    logic [TAG_WIDTH-1:0] rd_out;
    logic                 busy;

    // Pipeline side: issues operations, consumes results, kills on redirect.
    modport master (
        output flush, in_valid, funct3, op_a, op_b, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    // Unit side.
    modport slave (
        input  flush, in_valid, funct3, op_a, op_b, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide on magnitudes.
// Latency: XLEN+1 cycles from accept to out_valid; divide-by-zero/overflow fast path 1 cycle.
// Backpressure: one op at a time; result held in DONE until out_ready, in_ready low meanwhile.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]           state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [2*XLEN-1:0]    acc_q,    acc_d;
    logic [XLEN-1:0]      opnd_q,   opnd_d;    // multiplicand (mul) or divisor (div) magnitude
    logic                 neg_q,    neg_d;     // final result must be negated
    logic [2:0]           op_q,     op_d;
    logic [TAG_WIDTH-1:0] tag_q,    tag_d;
    logic [TAG_WIDTH-1:0] rd_out_q, rd_out_d;
    logic [XLEN-1:0]      result_q, result_d;

    // Request decode: operand signedness, magnitudes, result sign, fast-path detection.
    logic            req_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            req_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    // Decode the presented request.
    always_comb begin
        req_div  = bus.funct3[2];
        // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
        a_neg    = bus.op_a[XLEN-1] & ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                                       (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110));
        b_neg    = bus.op_b[XLEN-1] & ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) |
                                       (bus.funct3 == 3'b110));
        a_mag    = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
        b_mag    = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
        // Remainder follows the dividend; everything else is the XOR of the signs.
        req_neg  = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = req_div && (bus.op_b == '0);
        div_ovf  = req_div && !bus.funct3[0] && (bus.op_a == MOST_NEG) && (bus.op_b == '1);
        fast_res = '0;
        if (div_zero) begin
            fast_res = bus.funct3[1] ? bus.op_a : '1;
        end else if (div_ovf) begin
            fast_res = bus.funct3[1] ? '0 : bus.op_a;
        end
    end

    // One iteration of the datapath plus the sign-corrected, half-selected result.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_res;

    // Shift-add / restoring shift-subtract step and result formatting.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        rem_ge  = rem_sh >= {1'b0, opnd_q};
        // When rem_sh >= divisor the true difference is below the divisor, so XLEN bits suffice.
        rem_sub = rem_sh[XLEN-1:0] - opnd_q;
        if (op_q[2]) begin
            step = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                          : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? (~step + 1'b1) : step;
        quo_fix  = neg_q ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
        rem_fix  = neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fin_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quo_fix;
            default:                fin_res = rem_fix;
        endcase
    end

    logic accept;
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    // Next-state: accept into CALC or fast path, iterate, hold in DONE, flush wins over all.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        op_d     = op_q;
        tag_d    = tag_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = bus.funct3;
                    tag_d = bus.rd_in;
                    neg_d = req_neg;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                        rd_out_d = bus.rd_in;
                        acc_d    = '0;
                    end else begin
                        state_d = S_CALC;
                        // Low half holds the multiplier or the dividend; high half starts cleared.
                        acc_d   = {{XLEN{1'b0}}, req_div ? a_mag : b_mag};
                        opnd_d  = req_div ? b_mag : a_mag;
                    end
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                    rd_out_d = tag_q;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            tag_q    <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
endmodule
